// File: rtl/munch_vga_timing.sv
// munch_vga_timing
// ----------------
// Raster timing generator feeding the munch pattern renderer. It walks a
// pixel position across the configured raster and registers sync, display
// enable and a completed-frame counter alongside that position.
//
// Default parameters give 640x480@60 from a 25.175 MHz pixel clock.
//
// Optional build macro:
//   MUNCH_VGA_PIXDIV2_EN - an internal divide-by-2 toggle produces pix_tick,
//                          so a 50 MHz board clock yields the pixel rate.
//                          Without it pix_tick is tied high.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high (overrides en)
//   en           advance enable; 0 freezes every register
//   pix_tick     pixel strobe; counters move only when pix_tick & en
//   hpos         horizontal position, 0..H_TOTAL-1
//   vpos         vertical position, 0..V_TOTAL-1
//   display_on   high inside the visible H_ACTIVE x V_ACTIVE window
//   hsync        SYNC_ACTIVE level while hpos is inside the sync pulse
//   vsync        SYNC_ACTIVE level while vpos is inside the sync lines
//   line_start   one-tick strobe at hpos==0
//   frame_start  one-tick strobe at hpos==0 and vpos==0
//   frame_cnt    completed-frame counter, wraps 255->0
//
// H_TOTAL and V_TOTAL must each be at most 1024 so they fit the 10-bit
// position counters.

module munch_vga_timing #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       pix_tick,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Window bounds are kept 11 bits wide so an end bound equal to 1024
  // still compares correctly against the 10-bit position.
  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS_END  = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS_END  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic       adv;
  logic [9:0] h_next;
  logic [9:0] v_next;
  logic [7:0] fc_next;
  logic       de_next;
  logic       hs_next;
  logic       vs_next;

`ifdef MUNCH_VGA_PIXDIV2_EN
  // Divide-by-2 pixel strobe. Resetting to 1 makes the first enabled cycle
  // after reset a pixel tick; the toggle only moves while en is high so a
  // frozen raster resumes on the same phase.
  logic tick_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= 1'b1;
    end else if (en) begin
      tick_q <= ~tick_q;
    end
  end

  assign pix_tick = tick_q;
`else
  assign pix_tick = 1'b1;
`endif

  assign adv = pix_tick & en & ~rst;

  // Next raster position: hpos wraps at end of line and carries into vpos,
  // which in turn carries into the frame counter at the end of the frame.
  always_comb begin
    h_next  = hpos;
    v_next  = vpos;
    fc_next = frame_cnt;
    if (adv) begin
      if (hpos == H_LAST) begin
        h_next = 10'd0;
        if (vpos == V_LAST) begin
          v_next  = 10'd0;
          fc_next = frame_cnt + 8'd1;
        end else begin
          v_next = vpos + 10'd1;
        end
      end else begin
        h_next = hpos + 10'd1;
      end
    end
  end

  // Sync and display enable are decoded from the next position so that the
  // registered versions line up exactly with the hpos/vpos they accompany.
  always_comb begin
    de_next = ({1'b0, h_next} < H_VIS_END) && ({1'b0, v_next} < V_VIS_END);
    hs_next = (({1'b0, h_next} >= HS_START) && ({1'b0, h_next} < HS_END))
              ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_next = (({1'b0, v_next} >= VS_START) && ({1'b0, v_next} < VS_END))
              ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  // Reset returns to the top-left visible pixel with both syncs idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hpos       <= 10'd0;
      vpos       <= 10'd0;
      frame_cnt  <= 8'd0;
      display_on <= 1'b1;
      hsync      <= ~SYNC_ACTIVE;
      vsync      <= ~SYNC_ACTIVE;
    end else begin
      hpos       <= h_next;
      vpos       <= v_next;
      frame_cnt  <= fc_next;
      display_on <= de_next;
      hsync      <= hs_next;
      vsync      <= vs_next;
    end
  end

  // Strobes qualify the current position with the advance condition so they
  // last exactly one pixel tick and stay low while frozen or in reset.
  assign line_start  = adv & (hpos == 10'd0);
  assign frame_start = line_start & (vpos == 10'd0);

endmodule

// File: tb/tb_munch_vga_timing.sv
// tb_munch_vga_timing
// -------------------
// Drives two instances from the same clock/reset/enable: one with the
// default 640x480 timing (first-line horizontal checks) and one with a tiny
// 16x12 raster so full frames and the 256-frame wrap fit in a short run.
// Small raster: H 8/2/3/3 (hsync at hpos 10..12), V 6/2/2/2 (vsync at
// vpos 8..9), 192 cycles per frame.
// The driver enqueues hand-computed expected outputs; a monitor on the
// falling edge pops each one and compares it against the selected instance.

module tb_munch_vga_timing;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;

  logic       b_pix_tick, b_display_on, b_hsync, b_vsync, b_line_start, b_frame_start;
  logic [9:0] b_hpos, b_vpos;
  logic [7:0] b_frame_cnt;
  logic       s_pix_tick, s_display_on, s_hsync, s_vsync, s_line_start, s_frame_start;
  logic [9:0] s_hpos, s_vpos;
  logic [7:0] s_frame_cnt;

  typedef struct {
    bit          is_big;
    string       name;
    logic [33:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  bit count_on = 1'b0;
  int fs_cnt = 0, ls_cnt = 0, vs_low_cnt = 0, hs_low_cnt = 0, de_cnt = 0, pt_cnt = 0;

  always #5 clk = ~clk;

  munch_vga_timing u_big (
    .clk(clk), .rst(rst), .en(en), .pix_tick(b_pix_tick),
    .hpos(b_hpos), .vpos(b_vpos), .display_on(b_display_on),
    .hsync(b_hsync), .vsync(b_vsync), .line_start(b_line_start),
    .frame_start(b_frame_start), .frame_cnt(b_frame_cnt)
  );

  munch_vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_ACTIVE(1'b0)
  ) u_small (
    .clk(clk), .rst(rst), .en(en), .pix_tick(s_pix_tick),
    .hpos(s_hpos), .vpos(s_vpos), .display_on(s_display_on),
    .hsync(s_hsync), .vsync(s_vsync), .line_start(s_line_start),
    .frame_start(s_frame_start), .frame_cnt(s_frame_cnt)
  );

  // Inputs change just after the rising edge; they are seen by the next edge.
  task automatic apply_stimulus(input logic r, input logic e);
    @(posedge clk);
    #1;
    rst = r;
    en  = e;
  endtask

  // Queue an expected output vector for the next falling-edge sample.
  task automatic check_output(input bit is_big, input string name,
                              input int h, input int v, input int f,
                              input logic de, input logic hs, input logic vs,
                              input logic ls, input logic fs);
    exp_t e;
    e.is_big = is_big;
    e.name   = name;
    e.exp    = {10'(h), 10'(v), 8'(f), 1'b1, de, hs, vs, ls, fs};
    sb_q.push_back(e);
  endtask

  task automatic check_count(input string name, input int got, input int expd);
    checks++;
    if (got != expd) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, expd);
    end
  endtask

  // Monitor: compare every queued expectation, and accumulate raster
  // statistics of the small instance while the counting window is open.
  always @(negedge clk) begin
    logic [33:0] act;
    exp_t        e;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = e.is_big
            ? {b_hpos, b_vpos, b_frame_cnt, b_pix_tick, b_display_on, b_hsync, b_vsync, b_line_start, b_frame_start}
            : {s_hpos, s_vpos, s_frame_cnt, s_pix_tick, s_display_on, s_hsync, s_vsync, s_line_start, s_frame_start};
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("[TB] FAIL %s (%s): got h=%0d v=%0d fc=%0d pt,de,hs,vs,ls,fs=%b expected h=%0d v=%0d fc=%0d pt,de,hs,vs,ls,fs=%b",
                 e.name, e.is_big ? "big" : "small",
                 act[33:24], act[23:14], act[13:6], act[5:0],
                 e.exp[33:24], e.exp[23:14], e.exp[13:6], e.exp[5:0]);
      end
    end
    if (count_on) begin
      if (s_frame_start) fs_cnt++;
      if (s_line_start)  ls_cnt++;
      if (!s_vsync)      vs_low_cnt++;
      if (!s_hsync)      hs_low_cnt++;
      if (s_display_on)  de_cnt++;
      if (s_pix_tick)    pt_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held for three edges, then released.
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b1);
    check_output(1'b1, "reset_hold", 0, 0, 0, 1, 1, 1, 0, 0);
    check_output(1'b0, "reset_hold", 0, 0, 0, 1, 1, 1, 0, 0);
    apply_stimulus(1'b0, 1'b1);
    check_output(1'b1, "release", 0, 0, 0, 1, 1, 1, 1, 1);
    check_output(1'b0, "release", 0, 0, 0, 1, 1, 1, 1, 1);

    // First line of the big raster; small raster runs past four frames.
    for (int j = 1; j <= 800; j++) begin
      apply_stimulus(1'b0, 1'b1);
      case (j)
        7:   check_output(1'b0, "s_h7",      7,  0, 0, 1, 1, 1, 0, 0);
        8:   check_output(1'b0, "s_de_fall", 8,  0, 0, 0, 1, 1, 0, 0);
        10:  check_output(1'b0, "s_hs_fall", 10, 0, 0, 0, 0, 1, 0, 0);
        12:  check_output(1'b0, "s_hs_last", 12, 0, 0, 0, 0, 1, 0, 0);
        13:  check_output(1'b0, "s_hs_rise", 13, 0, 0, 0, 1, 1, 0, 0);
        16:  check_output(1'b0, "s_line1",   0,  1, 0, 1, 1, 1, 1, 0);
        95:  check_output(1'b0, "s_v5_end",  15, 5, 0, 0, 1, 1, 0, 0);
        96:  check_output(1'b0, "s_v6_dark", 0,  6, 0, 0, 1, 1, 1, 0);
        127: check_output(1'b0, "s_v7_end",  15, 7, 0, 0, 1, 1, 0, 0);
        128: check_output(1'b0, "s_vs_fall", 0,  8, 0, 0, 1, 0, 1, 0);
        159: check_output(1'b0, "s_vs_last", 15, 9, 0, 0, 1, 0, 0, 0);
        160: check_output(1'b0, "s_vs_rise", 0, 10, 0, 0, 1, 1, 1, 0);
        191: check_output(1'b0, "s_f0_end",  15, 11, 0, 0, 1, 1, 0, 0);
        192: check_output(1'b0, "s_f1",      0,  0, 1, 1, 1, 1, 1, 1);
        639: check_output(1'b1, "b_h639",    639, 0, 0, 1, 1, 1, 0, 0);
        640: check_output(1'b1, "b_de_fall", 640, 0, 0, 0, 1, 1, 0, 0);
        655: check_output(1'b1, "b_h655",    655, 0, 0, 0, 1, 1, 0, 0);
        656: check_output(1'b1, "b_hs_fall", 656, 0, 0, 0, 0, 1, 0, 0);
        751: check_output(1'b1, "b_hs_last", 751, 0, 0, 0, 0, 1, 0, 0);
        752: check_output(1'b1, "b_hs_rise", 752, 0, 0, 0, 1, 1, 0, 0);
        799: check_output(1'b1, "b_h799",    799, 0, 0, 0, 1, 1, 0, 0);
        800: begin
          check_output(1'b1, "b_line1",  0, 1, 0, 1, 1, 1, 1, 0);
          check_output(1'b0, "s_f4_v2",  0, 2, 4, 1, 1, 1, 1, 0);
        end
        default: ;
      endcase
    end

    // Freeze with en=0 mid-frame at a line start (small h0 v4, big h32 v1).
    for (int j = 801; j <= 831; j++) apply_stimulus(1'b0, 1'b1);
    for (int k = 0; k < 50; k++) begin
      apply_stimulus(1'b0, 1'b0);
      check_output(1'b0, "freeze", 0, 4, 4, 1, 1, 1, 0, 0);
      check_output(1'b1, "freeze", 32, 1, 0, 1, 1, 1, 0, 0);
    end
    apply_stimulus(1'b0, 1'b1);
    check_output(1'b0, "resume_edge", 0, 4, 4, 1, 1, 1, 1, 0);
    check_output(1'b1, "resume_edge", 32, 1, 0, 1, 1, 1, 0, 0);
    apply_stimulus(1'b0, 1'b1);
    check_output(1'b0, "resume_next", 1, 4, 4, 1, 1, 1, 0, 0);
    check_output(1'b1, "resume_next", 33, 1, 0, 1, 1, 1, 0, 0);

    // Reset mid-frame while the small raster sits in both sync pulses.
    for (int j = 834; j <= 922; j++) apply_stimulus(1'b0, 1'b1);
    check_output(1'b0, "pre_reset", 10, 9, 4, 0, 0, 0, 0, 0);
    check_output(1'b1, "pre_reset", 122, 1, 0, 1, 1, 1, 0, 0);
    apply_stimulus(1'b1, 1'b1);
    check_output(1'b0, "rst_assert", 11, 9, 4, 0, 0, 0, 0, 0);
    check_output(1'b1, "rst_assert", 123, 1, 0, 1, 1, 1, 0, 0);
    apply_stimulus(1'b1, 1'b1);
    check_output(1'b0, "mid_reset", 0, 0, 0, 1, 1, 1, 0, 0);
    check_output(1'b1, "mid_reset", 0, 0, 0, 1, 1, 1, 0, 0);
    apply_stimulus(1'b0, 1'b1);
    check_output(1'b0, "rerelease", 0, 0, 0, 1, 1, 1, 1, 1);
    check_output(1'b1, "rerelease", 0, 0, 0, 1, 1, 1, 1, 1);

    // 256 small frames from the fresh reset; statistics window covers them.
    for (int j = 1; j <= 49152; j++) begin
      apply_stimulus(1'b0, 1'b1);
      if (j == 1) count_on = 1'b1;
      case (j)
        191:   check_output(1'b0, "s_run_f0_end", 15, 11, 0, 0, 1, 1, 0, 0);
        192:   check_output(1'b0, "s_run_f1",     0,  0, 1, 1, 1, 1, 1, 1);
        19200: check_output(1'b0, "s_run_f100",   0,  0, 100, 1, 1, 1, 1, 1);
        49151: begin
          check_output(1'b0, "s_f255_end", 15, 11, 255, 0, 1, 1, 0, 0);
          check_output(1'b1, "b_run_end0", 351, 61, 0, 1, 1, 1, 0, 0);
        end
        49152: begin
          check_output(1'b0, "s_fc_wrap",  0, 0, 0, 1, 1, 1, 1, 1);
          check_output(1'b1, "b_run_end1", 352, 61, 0, 1, 1, 1, 0, 0);
        end
        default: ;
      endcase
    end
    @(negedge clk);
    #1;
    count_on = 1'b0;

    check_count("frame_start_pulses", fs_cnt, 256);
    check_count("line_start_pulses",  ls_cnt, 3072);
    check_count("vsync_low_cycles",   vs_low_cnt, 8192);
    check_count("hsync_low_cycles",   hs_low_cnt, 9216);
    check_count("display_on_cycles",  de_cnt, 12288);
    check_count("pix_tick_cycles",    pt_cnt, 49152);

    @(negedge clk);
    #1;
    check_count("scoreboard_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
